// File: rtl/wdt_irq_src.sv
// Watchdog timer plus a latched external-interrupt source for the CSR unit.
// Optional WDT_IRQ_SYNC_EN puts a 2-flop synchronizer in front of the irq edge detector.
module wdt_irq_src #(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wdt_we,
  input  logic [1:0]  wdt_addr,
  input  logic [31:0] wdt_wdata,
  output logic [31:0] wdt_rdata,
  input  logic        ext_irq_in,
  input  logic        irq_ack,
  output logic        interrupt,
  output logic        timeout
);

  // state    | meaning
  // IDLE     | watchdog disabled, cnt held at 0
  // COUNT    | counting up toward WTOCNT
  // EXPIRED  | limit reached, timeout asserted, cnt frozen
  typedef enum logic [1:0] {ST_IDLE, ST_COUNT, ST_EXPIRED} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   wtocnt_q, wtocnt_d;
  logic               wden_q, wden_d;
  logic               prev_q, prev_d;
  logic               pend_q, pend_d;
  logic               irq_lvl;
  logic               wden_wr, live_wr, wto_wr;
  logic               unused_wdata;

  assign wden_wr      = wdt_we && (wdt_addr == 2'd0);
  assign live_wr      = wdt_we && (wdt_addr == 2'd1) && wdt_wdata[0];
  assign wto_wr       = wdt_we && (wdt_addr == 2'd2);
  assign unused_wdata = ^wdt_wdata;

`ifdef WDT_IRQ_SYNC_EN
  logic sync1_q, sync1_d, sync2_q, sync2_d;

  always_comb begin
    sync1_d = ext_irq_in;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign irq_lvl = sync2_q;
`else
  assign irq_lvl = ext_irq_in;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wden_d   = wden_q;
    wtocnt_d = wtocnt_q;
    if (wden_wr) wden_d = wdt_wdata[0];
    if (wto_wr)  wtocnt_d = wdt_wdata[CNT_W-1:0];
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (wden_wr && wdt_wdata[0]) state_d = ST_COUNT;
      end
      ST_COUNT: begin
        // a refresh on the expiry edge takes priority over the compare
        if (live_wr)                  cnt_d   = '0;
        else if (cnt_q >= wtocnt_q)   state_d = ST_EXPIRED;
        else                          cnt_d   = cnt_q + CNT_W'(1);
      end
      ST_EXPIRED: begin
        if (live_wr) begin
          state_d = ST_COUNT;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    if (wden_wr && !wdt_wdata[0]) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end
  end

  always_comb begin
    prev_d = irq_lvl;
    pend_d = pend_q;
    if (irq_ack)              pend_d = 1'b0;
    if (irq_lvl && !prev_q)   pend_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      wtocnt_q <= '0;
      wden_q   <= 1'b0;
      prev_q   <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wtocnt_q <= wtocnt_d;
      wden_q   <= wden_d;
      prev_q   <= prev_d;
      pend_q   <= pend_d;
    end
  end

  always_comb begin
    wdt_rdata = '0;
    unique case (wdt_addr)
      2'd0:    wdt_rdata = {31'd0, wden_q};
      2'd2:    wdt_rdata = 32'(wtocnt_q);
      2'd3:    wdt_rdata = 32'(cnt_q);
      default: wdt_rdata = '0;
    endcase
  end

  assign timeout   = (state_q == ST_EXPIRED);
  assign interrupt = pend_q;

endmodule
